// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the byte-addressed data memory controller.
// Little-endian: byte 0 of a word lives in bits [7:0].
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Right-justified store data is copied into every lane; the byte enables pick the live ones.
  function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      SZ_WORD: return word;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM-stage load/store unit (master) and the memory controller (slave).
interface data_memory_ctrl_if #(
  parameter int ADDR_WIDTH = 18
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word storage split into four byte-wide lanes so each lane is a plain RAM with its own write enable.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          lane_mem[waddr] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane_mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte/half/word data memory controller with alignment/range checking and configurable wait states.
// The response registers load on the edge that enters RESP, so they are valid exactly during RESP.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 18,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  data_memory_ctrl_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e             state_reg, state_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic               write_reg;
  logic [1:0]         size_reg;
  logic               uns_reg;
  logic [IDX_W+1:0]   addr_reg;
  logic [31:0]        wdata_reg;
  logic               err_reg;
  logic               resp_valid_reg;
  logic [31:0]        resp_rdata_reg;
  logic               resp_err_reg;

  logic               in_idle;
  logic               req_err;
  logic               eff_write, eff_uns, eff_err;
  logic [1:0]         eff_size;
  logic [IDX_W+1:0]   eff_addr;
  logic               mem_we;
  logic [3:0]         mem_be;
  logic [31:0]        mem_wdata, mem_rdata;

  assign in_idle = (state_reg == ST_IDLE);
  assign req_err = (bus.req_size == SZ_RSVD)
                || misaligned(bus.req_size, bus.req_addr[1:0])
                || (32'(bus.req_addr[ADDR_WIDTH-1:2]) >= 32'(DEPTH_WORDS));

  // With zero wait states the response is built straight from the request being accepted.
  assign eff_write = in_idle ? bus.req_write             : write_reg;
  assign eff_size  = in_idle ? bus.req_size              : size_reg;
  assign eff_uns   = in_idle ? bus.req_unsigned          : uns_reg;
  assign eff_addr  = in_idle ? bus.req_addr[IDX_W+1:0]   : addr_reg;
  assign eff_err   = in_idle ? req_err                   : err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      write_reg <= 1'b0;
      size_reg  <= SZ_BYTE;
      uns_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (in_idle && bus.req_valid) begin
        write_reg <= bus.req_write;
        size_reg  <= bus.req_size;
        uns_reg   <= bus.req_unsigned;
        addr_reg  <= bus.req_addr[IDX_W+1:0];
        wdata_reg <= bus.req_wdata;
        err_reg   <= req_err;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_BUSY;
            cnt_next   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_BUSY: begin
        if (cnt_reg == 4'd0) state_next = ST_RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Stores commit on the edge leaving RESP, ahead of the next possible accept.
  always_comb begin
    mem_we    = (state_reg == ST_RESP) && write_reg && !err_reg && !rst;
    mem_be    = byte_enable(size_reg, addr_reg[1:0]);
    mem_wdata = replicate_wdata(size_reg, wdata_reg);
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .waddr (addr_reg[IDX_W+1:2]),
    .wdata (mem_wdata),
    .raddr (eff_addr[IDX_W+1:2]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= 32'h0;
      resp_err_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= (state_next == ST_RESP);
      if (state_next == ST_RESP) begin
        resp_rdata_reg <= (eff_write || eff_err) ? 32'h0
                        : load_extract(mem_rdata, eff_size, eff_addr[1:0], eff_uns);
        resp_err_reg   <= eff_err;
      end else begin
        resp_rdata_reg <= 32'h0;
        resp_err_reg   <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = in_idle;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_err   = resp_err_reg;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one instance with no wait states, one with three.
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst0, rst3;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  data_memory_ctrl_if #(.ADDR_WIDTH(18)) if0 ();
  data_memory_ctrl_if #(.ADDR_WIDTH(18)) if3 ();

  data_memory_ctrl #(.ADDR_WIDTH(18), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk), .rst (rst0), .bus (if0)
  );
  data_memory_ctrl #(.ADDR_WIDTH(18), .DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_dut3 (
    .clk (clk), .rst (rst3), .bus (if3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic w, input logic [1:0] sz, input logic u,
                        input logic [17:0] a, input logic [31:0] d);
    if0.req_valid = 1'b1; if0.req_write = w; if0.req_size = sz;
    if0.req_unsigned = u; if0.req_addr = a; if0.req_wdata = d;
  endtask

  task automatic drive3(input logic w, input logic [1:0] sz, input logic u,
                        input logic [17:0] a, input logic [31:0] d);
    if3.req_valid = 1'b1; if3.req_write = w; if3.req_size = sz;
    if3.req_unsigned = u; if3.req_addr = a; if3.req_wdata = d;
  endtask

  // Zero-wait transaction: response must be present in the cycle right after the accept edge.
  task automatic xact0(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [17:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    chk({tag, ".ready_pre"}, 32'(if0.req_ready), 32'd1);
    drive0(w, sz, u, a, d);
    @(negedge clk);
    if0.req_valid = 1'b0;
    chk({tag, ".resp_valid"}, 32'(if0.resp_valid), 32'd1);
    chk({tag, ".rdata"}, if0.resp_rdata, exp_rdata);
    chk({tag, ".err"}, 32'(if0.resp_err), 32'(exp_err));
    chk({tag, ".ready_resp"}, 32'(if0.req_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".resp_clear"}, 32'(if0.resp_valid), 32'd0);
  endtask

  // Three-wait transaction: ready low for four cycles, response only in the fourth.
  task automatic xact3(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [17:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    chk({tag, ".ready_pre"}, 32'(if3.req_ready), 32'd1);
    drive3(w, sz, u, a, d);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) if3.req_valid = 1'b0;
      chk($sformatf("%s.ready_c%0d", tag, k), 32'(if3.req_ready), 32'(k == 5));
      chk($sformatf("%s.valid_c%0d", tag, k), 32'(if3.resp_valid), 32'(k == 4));
      if (k == 4) begin
        chk({tag, ".rdata"}, if3.resp_rdata, exp_rdata);
        chk({tag, ".err"}, 32'(if3.resp_err), 32'(exp_err));
      end
    end
  endtask

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_size = SZ_WORD;
    if0.req_unsigned = 1'b0; if0.req_addr = '0; if0.req_wdata = '0;
    if3.req_valid = 1'b0; if3.req_write = 1'b0; if3.req_size = SZ_WORD;
    if3.req_unsigned = 1'b0; if3.req_addr = '0; if3.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;
    chk("rst.ready0", 32'(if0.req_ready), 32'd1);
    chk("rst.valid0", 32'(if0.resp_valid), 32'd0);
    chk("rst.rdata0", if0.resp_rdata, 32'h0);
    chk("rst.err0", 32'(if0.resp_err), 32'd0);
    chk("rst.ready3", 32'(if3.req_ready), 32'd1);
    chk("rst.valid3", 32'(if3.resp_valid), 32'd0);

    // Zero wait states: basic store/load, extension and lane selection.
    xact0("sw10",   1'b1, SZ_WORD, 1'b0, 18'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    xact0("lw10",   1'b0, SZ_WORD, 1'b0, 18'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    xact0("lb10",   1'b0, SZ_BYTE, 1'b0, 18'h10, 32'h0,        32'hFFFFFFEF, 1'b0);
    xact0("lbu13",  1'b0, SZ_BYTE, 1'b1, 18'h13, 32'h0,        32'h000000DE, 1'b0);
    xact0("lh12",   1'b0, SZ_HALF, 1'b0, 18'h12, 32'h0,        32'hFFFFDEAD, 1'b0);
    xact0("lhu10",  1'b0, SZ_HALF, 1'b1, 18'h10, 32'h0,        32'h0000BEEF, 1'b0);
    xact0("sb11",   1'b1, SZ_BYTE, 1'b0, 18'h11, 32'hAAAAAA55, 32'h0,        1'b0);
    xact0("lw10b",  1'b0, SZ_WORD, 1'b0, 18'h10, 32'h0,        32'hDEAD55EF, 1'b0);
    xact0("lb11",   1'b0, SZ_BYTE, 1'b0, 18'h11, 32'h0,        32'h00000055, 1'b0);

    // Errors never write and return zero data.
    xact0("sh11",   1'b1, SZ_HALF, 1'b0, 18'h11, 32'h00001234, 32'h0,        1'b1);
    xact0("lw10c",  1'b0, SZ_WORD, 1'b0, 18'h10, 32'h0,        32'hDEAD55EF, 1'b0);
    xact0("lw402",  1'b0, SZ_WORD, 1'b0, 18'h402, 32'h0,       32'h0,        1'b1);
    xact0("lw400",  1'b0, SZ_WORD, 1'b0, 18'h400, 32'h0,       32'h0,        1'b1);
    xact0("lw12",   1'b0, SZ_WORD, 1'b0, 18'h12, 32'h0,        32'h0,        1'b1);
    xact0("rsvd",   1'b0, SZ_RSVD, 1'b0, 18'h10, 32'h0,        32'h0,        1'b1);

    // Upper half store, and the last legal word.
    xact0("sh12",   1'b1, SZ_HALF, 1'b0, 18'h12, 32'hFFFF8001, 32'h0,        1'b0);
    xact0("lh12b",  1'b0, SZ_HALF, 1'b0, 18'h12, 32'h0,        32'hFFFF8001, 1'b0);
    xact0("lw10d",  1'b0, SZ_WORD, 1'b0, 18'h10, 32'h0,        32'h800155EF, 1'b0);
    xact0("sw3fc",  1'b1, SZ_WORD, 1'b0, 18'h3FC, 32'hCAFEF00D, 32'h0,       1'b0);
    xact0("lw3fc",  1'b0, SZ_WORD, 1'b0, 18'h3FC, 32'h0,       32'hCAFEF00D, 1'b0);

    // Three wait states: timing, error timing.
    xact3("w3.sw20", 1'b1, SZ_WORD, 1'b0, 18'h20, 32'h11112222, 32'h0,        1'b0);
    xact3("w3.lw20", 1'b0, SZ_WORD, 1'b0, 18'h20, 32'h0,        32'h11112222, 1'b0);
    xact3("w3.lw21", 1'b0, SZ_WORD, 1'b0, 18'h21, 32'h0,        32'h0,        1'b1);

    // A req_valid pulse while busy must be dropped.
    @(negedge clk);
    drive3(1'b0, SZ_HALF, 1'b1, 18'h22, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) if3.req_valid = 1'b0;
      if (k == 2) drive3(1'b1, SZ_WORD, 1'b0, 18'h20, 32'h0BAD0BAD);
      if (k == 3) if3.req_valid = 1'b0;
      chk($sformatf("w3.drop.ready_c%0d", k), 32'(if3.req_ready), 32'(k == 5));
      chk($sformatf("w3.drop.valid_c%0d", k), 32'(if3.resp_valid), 32'(k == 4));
      if (k == 4) chk("w3.drop.rdata", if3.resp_rdata, 32'h00001111);
    end
    repeat (3) begin
      @(negedge clk);
      chk("w3.drop.no_resp", 32'(if3.resp_valid), 32'd0);
    end
    xact3("w3.lw20b", 1'b0, SZ_WORD, 1'b0, 18'h20, 32'h0, 32'h11112222, 1'b0);

    // Reset while BUSY aborts the store with no response.
    @(negedge clk);
    drive3(1'b1, SZ_WORD, 1'b0, 18'h20, 32'h12345678);
    @(negedge clk);
    if3.req_valid = 1'b0;
    chk("w3.abort.busy", 32'(if3.req_ready), 32'd0);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk("w3.abort.ready", 32'(if3.req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("w3.abort.no_resp%0d", k), 32'(if3.resp_valid), 32'd0);
      @(negedge clk);
    end
    xact3("w3.lw20c", 1'b0, SZ_WORD, 1'b0, 18'h20, 32'h0, 32'h11112222, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor to the single-cycle word data memory of the 32-bit MIPS datapath.
- Adds byte-addressed access with byte/half/word sizes, sign/zero extension for loads, alignment and range checking, and a configurable wait-state count to model slower memory.
- Sits between the MEM-stage load/store unit and the storage array; the pipeline stalls while req_ready is low.

Parameters:
- ADDR_WIDTH, 18, width of the byte address.
- DEPTH_WORDS, 256, number of 32-bit words in storage; legal word index is 0..DEPTH_WORDS-1.
- WAIT_CYCLES, 0, extra cycles inserted between request accept and response; 0..15.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and able to accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  in  1  load zero-extends when 1 (lbu/lhu) and sign-extends when 0; ignored for word and stores.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified (the byte in [7:0], the half in [15:0]).
- resp_valid  out  1  one-cycle pulse marking request completion; issued for stores too.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, out of range, or reserved size.

Behaviour:
- Reset:
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, FSM in IDLE, wait counter 0.
  - Storage contents are not reset.
  - A reset during BUSY aborts the request: no write is committed and no response is issued.
- Byte order: little-endian within a word (byte 0 = bits [7:0]).
- Word index = req_addr[ADDR_WIDTH-1:2].
- Error checks, evaluated at accept:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - word index >= DEPTH_WORDS;
  - size 11.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. On req_valid, latch write, size, unsigned, addr, wdata and the error flag.
    - If WAIT_CYCLES=0 → RESP.
    - Otherwise load the counter with WAIT_CYCLES-1 and → BUSY.
  - BUSY: req_ready=0. Decrement the counter; when it reaches 0 → RESP.
  - RESP: req_ready=0.
    - Perform the access: a store commits the byte-enabled lanes only; a load reads the word, then selects and extends the lane.
    - Assert resp_valid=1 with resp_rdata/resp_err for exactly this one cycle, then → IDLE.
- Latency: the response appears WAIT_CYCLES+1 cycles after the accept edge. Throughput is one request per WAIT_CYCLES+2 cycles.
- Error requests follow the same timing. They never write, return resp_rdata=0 and resp_err=1.
- Read-after-write to the same word in back-to-back requests returns the new data; no bypass is needed because the write commits before the next accept.
- req_valid while req_ready=0 is ignored. The requester must hold the request until it is accepted.
- Byte-enable generation:
  - byte: 1 << addr[1:0];
  - half: 0011 or 1100 by addr[1];
  - word: 1111.
- Store data is replicated across lanes before masking.
- resp_valid, resp_rdata and resp_err are registered outputs. They return to 0 in the cycle after RESP.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum;
  - functions for byte-enable generation and load extraction/extension.
- One sub-module, dmem_array: a DEPTH_WORDS x 32 array with per-byte write enables and a combinational read. Keeps storage inferable as RAM.

Test Plan:
- WAIT_CYCLES=0: sw 0xDEADBEEF @0x10, then lw @0x10 → resp_rdata=0xDEADBEEF and resp_err=0; each response arrives 1 cycle after accept.
- Continuing from the previous test: lb @0x10 → 0xFFFFFFEF; lbu @0x13 → 0x000000DE; lh @0x12 → 0xFFFFDEAD; lhu @0x10 → 0x0000BEEF.
- sb 0x55 @0x11, then lw @0x10 → 0xDEAD55EF; other bytes are unchanged.
- Errors:
  - sh @0x11 → resp_err=1, and a subsequent lw @0x10 shows no change;
  - lw @0x402 (DEPTH_WORDS=256) → resp_err=1 and resp_rdata=0;
  - size 11 → resp_err=1.
- WAIT_CYCLES=3: lw accepted at cycle N → resp_valid only at cycle N+4; req_ready=0 for cycles N+1..N+4; a req_valid pulse in that window is dropped.
- WAIT_CYCLES=3: sw 0x12345678 @0x20, rst asserted in BUSY → no resp_valid; after reset, lw @0x20 returns the pre-store value.
